// File: rtl/playback_pkg.sv
// Shared types for the playback controller: key codes, FSM states and
// decoded keyboard commands.
package playback_pkg;

  localparam logic [7:0] KEY_E_UC = 8'h45;
  localparam logic [7:0] KEY_E_LC = 8'h65;
  localparam logic [7:0] KEY_D_UC = 8'h44;
  localparam logic [7:0] KEY_D_LC = 8'h64;
  localparam logic [7:0] KEY_F_UC = 8'h46;
  localparam logic [7:0] KEY_F_LC = 8'h66;
  localparam logic [7:0] KEY_B_UC = 8'h42;
  localparam logic [7:0] KEY_B_LC = 8'h62;
  localparam logic [7:0] KEY_R_UC = 8'h52;
  localparam logic [7:0] KEY_R_LC = 8'h72;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_DATA,
    SAMPLE0,
    SAMPLE1
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_FWD,
    CMD_BWD,
    CMD_RESTART
  } cmd_t;

  // Case-insensitive key decode; anything unrecognised is CMD_NONE.
  function automatic cmd_t decode_key(input logic [7:0] key);
    cmd_t cmd;
    case (key)
      KEY_E_UC, KEY_E_LC: cmd = CMD_START;
      KEY_D_UC, KEY_D_LC: cmd = CMD_STOP;
      KEY_F_UC, KEY_F_LC: cmd = CMD_FWD;
      KEY_B_UC, KEY_B_LC: cmd = CMD_BWD;
      KEY_R_UC, KEY_R_LC: cmd = CMD_RESTART;
      default:            cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/flash_word_fetch.sv
// Single-word flash reader: issues one read, tracks the outstanding word,
// buffers it, and can discard it when a restart overtakes the read.
module flash_word_fetch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              discard,
  input  logic              clear,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [DATA_W-1:0] flash_readdata,
  output logic              flash_read,
  output logic              accepted,
  output logic              done,
  output logic              dropped,
  output logic [DATA_W-1:0] word
);

  // Handshake: flash_read is held until a cycle with flash_waitrequest low
  // (the accept cycle); the data then arrives on a later flash_readdatavalid
  // pulse. Only one read is ever outstanding.
  logic pending;
  logic discard_q;
  logic drop_now;
  logic data_in;

  assign accepted = flash_read & ~flash_waitrequest;
  assign data_in  = pending & flash_readdatavalid;
  assign drop_now = discard_q | discard;
  assign done     = data_in & ~drop_now;
  assign dropped  = data_in & drop_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_read <= 1'b0;
      pending    <= 1'b0;
      discard_q  <= 1'b0;
      word       <= '0;
    end else begin
      if (data_in) pending <= 1'b0;
      if (accepted) begin
        flash_read <= 1'b0;
        pending    <= 1'b1;
      end else if (start && !flash_read && !pending) begin
        flash_read <= 1'b1;
      end
      // The flag only exists while a word is owed by the flash.
      discard_q <= (discard_q | (discard & (pending | accepted))) & ~data_in;
      if (clear) word <= '0;
      else if (done) word <= flash_readdata;
    end
  end

endmodule

// File: rtl/playback_ctrl.sv
// Keyboard-driven audio playback sequencer: fetches 32-bit flash words and
// emits 16-bit samples forward or backward. Define PLAYBACK_LOOP_EN to wrap.
module playback_ctrl
  import playback_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF,
  parameter int                DATA_W   = 32,
  parameter int                SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          kbd,
  input  logic                kbd_strobe,
  input  logic                sample_tick,
  input  logic                flash_waitrequest,
  input  logic                flash_readdatavalid,
  input  logic [DATA_W-1:0]   flash_readdata,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_addr,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                audio_valid,
  output logic                playing,
  output logic                dir_fwd,
  output logic [1:0]          state_dbg
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  cmd_t                cmd;
  logic                restart;
  logic                word_fwd;
  logic                fetch_start, discard, clear_buf;
  logic                accepted, done, dropped;
  logic [DATA_W-1:0]   word;
  logic                emit, advance, at_end;
  logic [SAMPLE_W-1:0] emit_data;
  logic [ADDR_W-1:0]   next_addr;

  assign state_dbg = state_q;

  flash_word_fetch #(.DATA_W(DATA_W)) u_fetch (
    .clk                 (clk),
    .reset               (reset),
    .start               (fetch_start),
    .discard             (discard),
    .clear               (clear_buf),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .flash_read          (flash_read),
    .accepted            (accepted),
    .done                (done),
    .dropped             (dropped),
    .word                (word)
  );

  always_comb begin
    cmd     = kbd_strobe ? decode_key(kbd) : CMD_NONE;
    restart = (cmd == CMD_RESTART);
  end

  always_comb begin
`ifdef PLAYBACK_LOOP_EN
    at_end = 1'b0;
    if (dir_fwd) next_addr = (flash_addr == MAX_ADDR) ? '0 : flash_addr + ADDR_ONE;
    else         next_addr = (flash_addr == '0) ? MAX_ADDR : flash_addr - ADDR_ONE;
`else
    at_end = dir_fwd ? (flash_addr == MAX_ADDR) : (flash_addr == '0);
    if (at_end)       next_addr = flash_addr;
    else if (dir_fwd) next_addr = flash_addr + ADDR_ONE;
    else              next_addr = flash_addr - ADDR_ONE;
`endif
  end

  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    discard     = 1'b0;
    clear_buf   = 1'b0;
    emit        = 1'b0;
    emit_data   = '0;
    advance     = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_start = playing;
        // A restart on the accept cycle is too late to retarget the read.
        if (accepted) begin
          state_d = WAIT_DATA;
          discard = restart;
        end
      end
      WAIT_DATA: begin
        discard = restart;
        if (done) state_d = SAMPLE0;
        else if (dropped) state_d = FETCH;
      end
      SAMPLE0: begin
        if (sample_tick && playing) begin
          emit      = 1'b1;
          emit_data = word_fwd ? word[SAMPLE_W-1:0] : word[DATA_W-1:SAMPLE_W];
          state_d   = SAMPLE1;
        end
        if (restart) begin
          clear_buf = 1'b1;
          state_d   = FETCH;
        end
      end
      SAMPLE1: begin
        if (sample_tick && playing) begin
          emit      = 1'b1;
          emit_data = word_fwd ? word[DATA_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
          advance   = 1'b1;
          state_d   = FETCH;
        end
        if (restart) begin
          clear_buf = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      flash_addr  <= '0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      playing     <= 1'b0;
      dir_fwd     <= 1'b1;
      word_fwd    <= 1'b1;
    end else begin
      state_q     <= state_d;
      audio_valid <= emit;
      if (emit) audio_data <= emit_data;
      // Half order is frozen per word; dir_fwd changes only steer the next word.
      if (done) word_fwd <= dir_fwd;
      if (restart) flash_addr <= dir_fwd ? '0 : MAX_ADDR;
      else if (advance) flash_addr <= next_addr;
      if (cmd == CMD_START) playing <= 1'b1;
      else if (cmd == CMD_STOP) playing <= 1'b0;
      else if (advance && at_end) playing <= 1'b0;
      if (cmd == CMD_FWD) dir_fwd <= 1'b1;
      else if (cmd == CMD_BWD) dir_fwd <= 1'b0;
    end
  end

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl: flash and keyboard are driven by tasks,
// emitted samples are checked against an expected queue.
module tb_playback_ctrl;
  import playback_pkg::*;

  localparam logic [22:0] MAX_ADDR = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  kbd;
  logic        kbd_strobe, sample_tick;
  logic        flash_waitrequest, flash_readdatavalid;
  logic [31:0] flash_readdata;
  logic        flash_read;
  logic [22:0] flash_addr;
  logic [15:0] audio_data;
  logic        audio_valid, playing, dir_fwd;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  playback_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .kbd                 (kbd),
    .kbd_strobe          (kbd_strobe),
    .sample_tick         (sample_tick),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .flash_read          (flash_read),
    .flash_addr          (flash_addr),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid),
    .playing             (playing),
    .dir_fwd             (dir_fwd),
    .state_dbg           (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every audio_valid pulse must match the oldest expected sample
  always @(negedge clk) begin
    if (reset === 1'b0 && audio_valid === 1'b1) begin
      if (exp_q.size() == 0) check("stray_valid", 32'(audio_valid), 32'd0);
      else check("sample", 32'(audio_data), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] k);
    kbd = k; kbd_strobe = 1'b1;
    step();
    kbd_strobe = 1'b0; kbd = 8'h00;
  endtask

  task automatic tick(input logic exp_valid, input logic [15:0] exp_data);
    if (exp_valid) exp_q.push_back(exp_data);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("tick_valid", 32'(audio_valid), 32'(exp_valid));
    check("tick_data", 32'(audio_data), 32'(exp_data));
  endtask

  task automatic wait_read(input int budget);
    int n = 0;
    while (flash_read !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("read_timeout", 32'(flash_read), 32'd1);
  endtask

  task automatic serve(input logic [22:0] addr, input logic [31:0] w, input int wait_n);
    int held;
    wait_read(50);
    check("req_addr", 32'(flash_addr), 32'(addr));
    held = 1;
    for (int i = 0; i < wait_n; i++) begin
      step();
      if (flash_read === 1'b1) held++;
    end
    flash_waitrequest = 1'b0;
    step();
    flash_waitrequest = 1'b1;
    check("read_hold", 32'(held), 32'(wait_n + 1));
    check("read_drop", 32'(flash_read), 32'd0);
    check("state_wait", 32'(state_dbg), 32'(WAIT_DATA));
    flash_readdata = w; flash_readdatavalid = 1'b1;
    step();
    flash_readdatavalid = 1'b0;
    check("state_s0", 32'(state_dbg), 32'(SAMPLE0));
  endtask

  task automatic play_fwd(input logic [22:0] addr, input logic [31:0] w);
    serve(addr, w, 1);
    tick(1'b1, w[15:0]);
    tick(1'b1, w[31:16]);
  endtask

  task automatic check_reset_values();
    check("rst_flash_read", 32'(flash_read), 32'd0);
    check("rst_flash_addr", 32'(flash_addr), 32'd0);
    check("rst_audio_data", 32'(audio_data), 32'd0);
    check("rst_audio_valid", 32'(audio_valid), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_dir_fwd", 32'(dir_fwd), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(FETCH));
  endtask

  function automatic logic [31:0] mk_word(input int a);
    logic [15:0] i16;
    i16 = 16'(a);
    return {16'hA000 | i16, 16'h5000 | i16};
  endfunction

  initial begin
    kbd = 8'h00; kbd_strobe = 1'b0; sample_tick = 1'b0;
    flash_waitrequest = 1'b1; flash_readdatavalid = 1'b0; flash_readdata = '0;
    reset = 1'b1;
    step(2);
    check_reset_values();
    reset = 1'b0;
    step(3);
    check("idle_no_read", 32'(flash_read), 32'd0);

    // non-command key changes nothing
    key("x");
    check("x_playing", 32'(playing), 32'd0);
    check("x_dir", 32'(dir_fwd), 32'd1);
    check("x_addr", 32'(flash_addr), 32'd0);
    check("x_no_read", 32'(flash_read), 32'd0);

    // start; first word with a 3-cycle waitrequest stall
    key("E");
    check("e_playing", 32'(playing), 32'd1);
    serve(23'd0, 32'hBBBB_AAAA, 3);
    tick(1'b1, 16'hAAAA);
    tick(1'b1, 16'hBBBB);
    for (int a = 1; a <= 4; a++) play_fwd(23'(a), mk_word(a));

    // backward from address 5
    key("b");
    check("b_dir", 32'(dir_fwd), 32'd0);
    serve(23'd5, 32'h2222_1111, 1);
    tick(1'b1, 16'h2222);
    tick(1'b1, 16'h1111);

    // pause mid-word, ticks ignored, resume with buffered half
    serve(23'd4, 32'h4444_3333, 0);
    tick(1'b1, 16'h4444);
    key("d");
    check("d_playing", 32'(playing), 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 16'h4444);
    key("e");
    tick(1'b1, 16'h3333);

    // forward again from 3 up to 9
    key("f");
    check("f_dir", 32'(dir_fwd), 32'd1);
    for (int a = 3; a <= 8; a++) play_fwd(23'(a), mk_word(a));

    // restart while waiting for data: word discarded, refetch from 0
    wait_read(50);
    check("req_addr9", 32'(flash_addr), 32'd9);
    flash_waitrequest = 1'b0;
    step();
    flash_waitrequest = 1'b1;
    check("state_wait9", 32'(state_dbg), 32'(WAIT_DATA));
    key("R");
    check("r_addr", 32'(flash_addr), 32'd0);
    check("r_state", 32'(state_dbg), 32'(WAIT_DATA));
    flash_readdata = 32'hDEAD_BEEF; flash_readdatavalid = 1'b1;
    step();
    flash_readdatavalid = 1'b0;
    check("drop_state", 32'(state_dbg), 32'(FETCH));
    for (int i = 0; i < 3; i++) tick(1'b0, 16'hA008);
    play_fwd(23'd0, 32'h0C0C_0B0B);

    // restart backward under a pending request, then run forward off the end
    wait_read(50);
    key("b");
    key("R");
    check("rb_addr", 32'(flash_addr), 32'(MAX_ADDR));
    check("rb_read_held", 32'(flash_read), 32'd1);
    key("f");
    serve(MAX_ADDR, 32'h7777_6666, 2);
    tick(1'b1, 16'h6666);
    tick(1'b1, 16'h7777);
`ifdef PLAYBACK_LOOP_EN
    check("end_playing", 32'(playing), 32'd1);
    check("end_addr", 32'(flash_addr), 32'd0);
    wait_read(50);
    check("wrap_req_addr", 32'(flash_addr), 32'd0);
`else
    check("end_playing", 32'(playing), 32'd0);
    check("end_addr", 32'(flash_addr), 32'(MAX_ADDR));
    for (int i = 0; i < 10; i++) begin
      step();
      check("end_no_read", 32'(flash_read), 32'd0);
    end
`endif

    // reset in the middle of a read
    key("R");
    key("E");
    wait_read(50);
    check("pre_rst_addr", 32'(flash_addr), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_values();
    step(2);
    reset = 1'b0;
    step(2);
    check("post_rst_no_read", 32'(flash_read), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
